multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Multicycle control unit, the parametrised successor to the single-cycle main decoder. A Moore FSM sequences each MIPS instruction through fetch, decode, execute, memory and writeback over several cycles, using one ALU and one unified memory port. Memory accesses use a ready handshake with a configurable timeout. Sits between the instruction register opcode field and the multicycle datapath muxes and enables.

## Interface
- MEM_TIMEOUT, 15, max wait cycles for mem_ready in a memory state; 0 disables timeout
- STATE_W, 4, width of the state register and `state` debug port
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- op  input  6  opcode from instruction register
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory completes current access this cycle
- MemRead, MemWrite, IorD, IRWrite  output  1 each  memory and IR controls
- RegDst, MemtoReg, RegWrite  output  1 each  register-file controls
- ALUSrcA  output  1  ALU A-mux select
- ALUSrcB, ALUop, PCSrc  output  2 each  ALU B-mux select, ALU op class, PC source
- PCWrite, branch  output  1 each  unconditional and conditional PC write
- pc_en  output  1  PCWrite | (branch & zero)
- illegal_op  output  1  one-cycle pulse on an unsupported opcode
- mem_timeout  output  1  one-cycle pulse on an abandoned memory access
- state  output  STATE_W  current state encoding

## Operation
- States and encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
  - EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11
- Output defaults: every output not listed for a state is 0.
- FETCH: MemRead=1, ALUSrcB=01.
  - IRWrite=PCWrite=mem_ready (Mealy on the handshake).
  - mem_ready -> DECODE, else stay.
- DECODE: ALUSrcB=11. Next state by op:
  - 100011 and 101011 -> MEMADR
  - 000000 -> EXEC
  - 000100 -> BRANCH
  - 001000 -> ADDIEX
  - 000010 -> JUMP (macro only)
  - any other op -> FETCH, with illegal_op pulsed for that cycle
- MEMADR: ALUSrcA=1, ALUSrcB=10. Next state is MEMRD if op=100011, else MEMWR.
- MEMRD: IorD=1, MemRead=1. mem_ready -> MEMWB.
- MEMWB: MemtoReg=1, RegWrite=1. Next state FETCH.
- MEMWR: IorD=1, MemWrite=1. mem_ready -> FETCH.
- EXEC: ALUSrcA=1, ALUop=10. Next state ALUWB.
- ALUWB: RegDst=1, RegWrite=1. Next state FETCH.
- BRANCH: ALUSrcA=1, ALUop=01, PCSrc=01, branch=1. Next state FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10. Next state ADDIWB.
- ADDIWB: RegWrite=1. Next state FETCH.
- JUMP: PCSrc=10, PCWrite=1. Next state FETCH.
- Unused encodings 12-15 -> FETCH next cycle, all outputs 0.
- Wait counter (memory states only):
  - Width $clog2(MEM_TIMEOUT+1); cleared on entry to FETCH, MEMRD or MEMWR.
  - Increments each cycle the FSM waits with mem_ready=0.
  - When count==MEM_TIMEOUT and mem_ready=0: pulse mem_timeout and go to FETCH. IRWrite, PCWrite and RegWrite stay 0 that cycle.
  - mem_ready in the same cycle as the timeout: ready wins, no timeout.

## Timing
- Reset (rst_n low, asynchronous):
  - state=FETCH, counter=0.
  - All strobes forced 0: MemRead, MemWrite, IRWrite, PCWrite, RegWrite, branch, pc_en, illegal_op, mem_timeout.
  - Reset mid-instruction abandons it with no writeback.
- First FETCH is the cycle after rst_n deasserts.
- Cycles per instruction with zero-wait memory: R-type 4, lw 5, sw 4, beq 3, addi 4, j 3. Each wait cycle adds 1.
- Outputs are combinational from state, plus mem_ready in FETCH and zero in pc_en. No registered output lag.

## Configuration
- JUMP_EN defined:
  - Opcode 000010 decodes to the JUMP state.
- JUMP_EN undefined:
  - JUMP state is not built.
  - 000010 is illegal: DECODE -> FETCH with illegal_op pulsed.
  - PCSrc never equals 10.

## Test plan
- Reset, then lw (op=100011) with mem_ready held 1 -> states 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in cycle 5.
- R-type (op=000000) -> 0,1,6,7; ALUop=10 in EXEC; RegDst=RegWrite=1 in ALUWB.
- beq (op=000100) with zero=1, then with zero=0 -> pc_en=1 in BRANCH for zero=1 only; PCSrc=01.
- MEM_TIMEOUT=3, FETCH with mem_ready=0 -> mem_timeout pulses after 3 wait cycles; IRWrite never 1; state returns to 0.
- op=000010 -> with JUMP_EN: PCSrc=10, PCWrite=1 in state 11. Without JUMP_EN: illegal_op=1 in DECODE, next state 0.
- rst_n dropped during MEMWR -> MemWrite=0 immediately, state=0, no store.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback with one ALU and one memory port.
// Latency: outputs are combinational from state (plus mem_ready in FETCH, zero in pc_en); 3-5 cycles per instruction plus memory waits.
// Backpressure: memory states hold until mem_ready, abandoning to FETCH after MEM_TIMEOUT waits. Optional JUMP_EN macro builds the j instruction.
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 15,
  parameter int STATE_W     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         op,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IorD,
  output logic               IRWrite,
  output logic               RegDst,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUop,
  output logic [1:0]         PCSrc,
  output logic               PCWrite,
  output logic               branch,
  output logic               pc_en,
  output logic               illegal_op,
  output logic               mem_timeout,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // A zero timeout leaves a 1-bit counter that never moves.
  localparam int              CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TMO  = CNT_W'(MEM_TIMEOUT);

  state_t           cur, nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic             waiting;
  logic             tmo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur <= FETCH;
    end else begin
      cur <= nxt;
    end
  end

  // Any transition (including a timeout re-entering FETCH) restarts the wait count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (nxt != cur || tmo) begin
      wait_cnt <= '0;
    end else if (waiting && MEM_TIMEOUT != 0) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_comb begin
    nxt         = cur;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IorD        = 1'b0;
    IRWrite     = 1'b0;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUop       = 2'b00;
    PCSrc       = 2'b00;
    PCWrite     = 1'b0;
    branch      = 1'b0;
    illegal_op  = 1'b0;
    mem_timeout = 1'b0;

    waiting = ((cur == FETCH) || (cur == MEMRD) || (cur == MEMWR)) && !mem_ready;
    tmo     = waiting && (MEM_TIMEOUT != 0) && (wait_cnt == TMO);

    case (cur)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        if (mem_ready) nxt = DECODE;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        case (op)
          OP_LW, OP_SW: nxt = MEMADR;
          OP_RTYPE:     nxt = EXEC;
          OP_BEQ:       nxt = BRANCH;
          OP_ADDI:      nxt = ADDIEX;
`ifdef JUMP_EN
          OP_J:         nxt = JUMP;
`endif
          default: begin
            nxt        = FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        nxt     = (op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
        if (mem_ready) nxt = MEMWB;
      end
      MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        nxt      = FETCH;
      end
      MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready) nxt = FETCH;
      end
      EXEC: begin
        ALUSrcA = 1'b1;
        ALUop   = 2'b10;
        nxt     = ALUWB;
      end
      ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        nxt      = FETCH;
      end
      BRANCH: begin
        ALUSrcA = 1'b1;
        ALUop   = 2'b01;
        PCSrc   = 2'b01;
        branch  = 1'b1;
        nxt     = FETCH;
      end
      ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        nxt     = ADDIWB;
      end
      ADDIWB: begin
        RegWrite = 1'b1;
        nxt      = FETCH;
      end
`ifdef JUMP_EN
      JUMP: begin
        PCSrc   = 2'b10;
        PCWrite = 1'b1;
        nxt     = FETCH;
      end
`endif
      default: nxt = FETCH;
    endcase

    if (tmo) begin
      nxt         = FETCH;
      mem_timeout = 1'b1;
    end

    // While reset is asserted no strobe may reach the datapath or memory.
    if (!rst_n) begin
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      PCWrite     = 1'b0;
      RegWrite    = 1'b0;
      branch      = 1'b0;
      illegal_op  = 1'b0;
      mem_timeout = 1'b0;
    end

    pc_en = PCWrite | (branch & zero);
  end

  assign state = STATE_W'(cur);

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: instruction table, hand-written timeout/reset corners,
// and random instruction streams checked against a per-instruction state-path model.
module tb_multicycle_controller;
  localparam int TMO = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] op = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       MemRead, MemWrite, IorD, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUop, PCSrc;
  logic       PCWrite, branch, pc_en, illegal_op, mem_timeout;
  logic [3:0] state;
  logic [18:0] outv;

  multicycle_controller #(.MEM_TIMEOUT(TMO), .STATE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUop(ALUop), .PCSrc(PCSrc), .PCWrite(PCWrite),
    .branch(branch), .pc_en(pc_en), .illegal_op(illegal_op), .mem_timeout(mem_timeout),
    .state(state)
  );

  assign outv = {MemRead, MemWrite, IorD, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                 ALUSrcB, ALUop, PCSrc, PCWrite, branch, pc_en, illegal_op, mem_timeout};

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      if (bad <= 30) $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic logic is_legal(input logic [5:0] o);
    case (o)
      6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000: return 1'b1;
`ifdef JUMP_EN
      6'b000010: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  // Control word each state must present, straight from the per-state output list.
  function automatic logic [18:0] exp_vec(input int st, input logic [5:0] o, input logic z,
                                          input logic rdy, input logic to);
    logic mr, mw, iord, irw, rd, m2r, rw, asa, pcw, br, ill;
    logic [1:0] asb, aop, pcs;
    {mr, mw, iord, irw, rd, m2r, rw, asa, pcw, br, ill} = '0;
    asb = 2'd0; aop = 2'd0; pcs = 2'd0;
    case (st)
      0:  begin mr = 1; asb = 2'd1; irw = rdy; pcw = rdy; end
      1:  begin asb = 2'd3; ill = !is_legal(o); end
      2:  begin asa = 1; asb = 2'd2; end
      3:  begin iord = 1; mr = 1; end
      4:  begin m2r = 1; rw = 1; end
      5:  begin iord = 1; mw = 1; end
      6:  begin asa = 1; aop = 2'd2; end
      7:  begin rd = 1; rw = 1; end
      8:  begin asa = 1; aop = 2'd1; pcs = 2'd1; br = 1; end
      9:  begin asa = 1; asb = 2'd2; end
      10: rw = 1;
      11: begin pcs = 2'd2; pcw = 1; end
      default: ;
    endcase
    return {mr, mw, iord, irw, rd, m2r, rw, asa, asb, aop, pcs, pcw, br, pcw | (br & z), ill, to};
  endfunction

  // Reference: the list of states an instruction visits, consumed one step per completed cycle.
  int seq[$];
  function automatic void build(input logic [5:0] o);
    seq = {0, 1};
    case (o)
      6'b100011: seq = {seq, 2, 3, 4};
      6'b101011: seq = {seq, 2, 5};
      6'b000000: seq = {seq, 6, 7};
      6'b000100: seq.push_back(8);
      6'b001000: seq = {seq, 9, 10};
`ifdef JUMP_EN
      6'b000010: seq.push_back(11);
`endif
      default: ;
    endcase
  endfunction

  typedef struct {
    logic [5:0] op;
    logic       zero;
    int         cycles;
    int         last;
    logic       pc_en_x;
    logic       ill;
  } vec_t;

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  function automatic logic [5:0] pick_op();
    logic [5:0] ops [7];
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010, 6'b111111};
    return (($urandom % 10) == 0) ? 6'($urandom) : ops[$urandom % 7];
  endfunction

  initial begin
    vec_t vt [8];
    int cyc, last;
    logic pcs, ill, stall, to, is_mem;
    int waits, cur;

    vt[0] = '{6'b100011, 1'b0, 5, 4, 1'b0, 1'b0};
    vt[1] = '{6'b101011, 1'b0, 4, 5, 1'b0, 1'b0};
    vt[2] = '{6'b000000, 1'b0, 4, 7, 1'b0, 1'b0};
    vt[3] = '{6'b000100, 1'b1, 3, 8, 1'b1, 1'b0};
    vt[4] = '{6'b000100, 1'b0, 3, 8, 1'b0, 1'b0};
    vt[5] = '{6'b001000, 1'b0, 4, 10, 1'b0, 1'b0};
`ifdef JUMP_EN
    vt[6] = '{6'b000010, 1'b0, 3, 11, 1'b1, 1'b0};
`else
    vt[6] = '{6'b000010, 1'b0, 2, 1, 1'b0, 1'b1};
`endif
    vt[7] = '{6'b111111, 1'b0, 2, 1, 1'b0, 1'b1};

    // Reset state: FETCH with every strobe held low.
    mem_ready = 1'b1;
    #12;
    check("reset_state", 32'(state), 32'd0);
    check("reset_strobes", 32'({MemRead, MemWrite, IRWrite, PCWrite, RegWrite, branch, pc_en, illegal_op, mem_timeout}), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Instruction table with zero-wait memory.
    for (int i = 0; i < 8; i++) begin
      op = vt[i].op; zero = vt[i].zero; mem_ready = 1'b1;
      cyc = 0; last = 0; pcs = 0; ill = 0;
      do begin
        @(negedge clk);
        cyc++;
        if (state != 0) begin
          last = int'(state);
          if (pc_en) pcs = 1;
        end
        if (illegal_op) ill = 1;
        @(posedge clk); #1;
      end while (state != 0 && cyc < 20);
      check($sformatf("tbl%0d_cycles", i), 32'(cyc), 32'(vt[i].cycles));
      check($sformatf("tbl%0d_last_state", i), 32'(last), 32'(vt[i].last));
      check($sformatf("tbl%0d_pc_en", i), 32'(pcs), 32'(vt[i].pc_en_x));
      check($sformatf("tbl%0d_illegal", i), 32'(ill), 32'(vt[i].ill));
    end

    // FETCH timeout: three waits, then the pulse on the fourth cycle, then a fresh FETCH.
    do_reset();
    op = 6'b000000; mem_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      check($sformatf("fto_state_c%0d", i), 32'(state), 32'd0);
      check($sformatf("fto_pulse_c%0d", i), 32'(mem_timeout), 32'(i == 4));
      check($sformatf("fto_irwrite_c%0d", i), 32'(IRWrite), 32'd0);
      @(posedge clk); #1;
    end

    // MEMRD: ready arriving exactly at the timeout count wins.
    do_reset();
    op = 6'b100011; mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("rdwin_in_memrd", 32'(state), 32'd3);
    mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 mem_ready = 1'b1;
    @(negedge clk);
    check("rdwin_no_timeout", 32'(mem_timeout), 32'd0);
    check("rdwin_still_memrd", 32'(state), 32'd3);
    @(posedge clk); #1;
    check("rdwin_to_memwb", 32'(state), 32'd4);

    // Reset dropped in the middle of a store.
    do_reset();
    op = 6'b101011; mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 mem_ready = 1'b0;
    @(negedge clk);
    check("rstwr_memwrite_before", 32'(MemWrite), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rstwr_memwrite_after", 32'(MemWrite), 32'd0);
    check("rstwr_state", 32'(state), 32'd0);
    check("rstwr_memread", 32'(MemRead), 32'd0);

    // Random instruction stream against the path model.
    @(posedge clk);
    #1 rst_n = 1'b1;
    op = pick_op(); build(op); waits = 0;
    stall = (($urandom % 6) == 0);
    mem_ready = stall ? (($urandom % 8) == 0) : (($urandom % 4) != 0);
    zero = 1'($urandom);
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      cur = seq[0];
      is_mem = (cur == 0) || (cur == 3) || (cur == 5);
      to = is_mem && !mem_ready && (waits == TMO);
      check($sformatf("rnd%0d_state", n), 32'(state), 32'(cur));
      check($sformatf("rnd%0d_ctrl", n), 32'(outv), 32'(exp_vec(cur, op, zero, mem_ready, to)));
      @(posedge clk);
      if (to) begin
        seq.delete(); waits = 0;
      end else if (is_mem && !mem_ready) begin
        waits++;
      end else begin
        void'(seq.pop_front()); waits = 0;
      end
      #1;
      if (seq.size() == 0) begin
        op = pick_op(); build(op);
        stall = (($urandom % 6) == 0);
      end
      mem_ready = stall ? (($urandom % 8) == 0) : (($urandom % 4) != 0);
      zero = 1'($urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
